pll_lock_supervisor: RTL and testbench

//   Return-path companion to the rPLL wrapper. It consumes the PLL LOCK output and drives the PLL RESET input.
//   - Sequences PLL reset pulses and qualifies lock.
//   - Holds the system reset until lock has stayed stable, then releases it.
//   - Retries a PLL that fails to lock, and logs lock losses.
//   - Runs on the 27 MHz board clock, never on a PLL output.

---
 rtl/pll_lock_supervisor.sv | 160 ++++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
// Purpose     : drives rPLL RESET, qualifies LOCK and holds sys_rst until lock is stable; retries and logs losses.
// Latency     : pll_lock reaches the FSM after 2 sync flops; registered outputs follow the state in the same cycle it is entered.
// Backpressure: none; free-running on the board clock, pll_lock is sampled every cycle and nothing stalls.
module pll_lock_supervisor #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_WAIT      = 27000,
    parameter int STABLE_CYCLES  = 2700,
    parameter int MAX_RETRIES    = 3,
    parameter int CNT_W          = 16,
    localparam int RETRY_W       = $clog2(MAX_RETRIES + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pll_lock,
    output logic               pll_reset,
    output logic               sys_rst,
    output logic               locked_ok,
    output logic               fault,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [7:0]         loss_cnt
);

    // Terminal counts for the single shared timer; compared with == only,
    // the timer is cleared on every state change so it never wraps.
    localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   WAIT_LAST   = CNT_W'(LOCK_WAIT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);
    localparam logic [7:0]         LOSS_SAT    = 8'hFF;

    typedef enum logic [2:0] {
        ST_PLL_RST    = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_STABLE_CHK = 3'd2,
        ST_RUN        = 3'd3,
        ST_FAULT      = 3'd4
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   timer;
    logic [CNT_W-1:0]   timer_nxt;
    logic [RETRY_W-1:0] retry_q;
    logic [RETRY_W-1:0] retry_nxt;
    logic [7:0]         loss_q;
    logic [7:0]         loss_nxt;

    // LOCK comes from the PLL and is asynchronous here; two flops, no filtering.
    logic lock_meta;
    logic lock_s;

    // Two-flop synchronizer for pll_lock, cleared by rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

    // State, timer and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_PLL_RST;
            timer   <= '0;
            retry_q <= '0;
            loss_q  <= '0;
        end else begin
            state   <= state_nxt;
            timer   <= timer_nxt;
            retry_q <= retry_nxt;
            loss_q  <= loss_nxt;
        end
    end

    // Next-state, timer and counter updates.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        retry_nxt = retry_q;
        loss_nxt  = loss_q;
        case (state)
            ST_PLL_RST: begin
                if (timer == RST_LAST) begin
                    state_nxt = ST_WAIT_LOCK;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + CNT_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                // A lock seen on the timeout cycle still counts as a lock.
                if (lock_s) begin
                    state_nxt = ST_STABLE_CHK;
                    timer_nxt = '0;
                end else if (timer == WAIT_LAST) begin
                    retry_nxt = retry_q + RETRY_W'(1);
                    timer_nxt = '0;
                    if (retry_nxt == RETRY_MAX) begin
                        state_nxt = ST_FAULT;
                    end else begin
                        state_nxt = ST_PLL_RST;
                    end
                end else begin
                    timer_nxt = timer + CNT_W'(1);
                end
            end
            ST_STABLE_CHK: begin
                // A dropout restarts qualification but is not a failed attempt.
                if (!lock_s) begin
                    state_nxt = ST_WAIT_LOCK;
                    timer_nxt = '0;
                end else if (timer == STABLE_LAST) begin
                    state_nxt = ST_RUN;
                    timer_nxt = '0;
                    retry_nxt = '0;
                end else begin
                    timer_nxt = timer + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    if (loss_q != LOSS_SAT) begin
                        loss_nxt = loss_q + 8'd1;
                    end
                    state_nxt = ST_PLL_RST;
                    timer_nxt = '0;
                end
            end
            ST_FAULT: begin
                // Terminal until rst; everything holds.
            end
            default: begin
                state_nxt = ST_PLL_RST;
                timer_nxt = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change together with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            pll_reset <= 1'b1;
            sys_rst   <= 1'b1;
            locked_ok <= 1'b0;
            fault     <= 1'b0;
        end else begin
            pll_reset <= (state_nxt == ST_PLL_RST);
            sys_rst   <= (state_nxt != ST_RUN);
            locked_ok <= (state_nxt == ST_RUN);
            fault     <= (state_nxt == ST_FAULT);
        end
    end

    assign retry_cnt = retry_q;
    assign loss_cnt  = loss_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
module tb_pll_lock_supervisor;

    localparam int P_RST  = 4;
    localparam int P_WAIT = 20;
    localparam int P_STAB = 8;
    localparam int P_MAXR = 2;

    localparam int SIG_PR  = 0;
    localparam int SIG_SR  = 1;
    localparam int SIG_FLT = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_lock;
    logic       pll_reset;
    logic       sys_rst;
    logic       locked_ok;
    logic       fault;
    logic [1:0] retry_cnt;
    logic [7:0] loss_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    pll_lock_supervisor #(
        .PLL_RST_CYCLES(P_RST),
        .LOCK_WAIT     (P_WAIT),
        .STABLE_CYCLES (P_STAB),
        .MAX_RETRIES   (P_MAXR),
        .CNT_W         (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pll_lock (pll_lock),
        .pll_reset(pll_reset),
        .sys_rst  (sys_rst),
        .locked_ok(locked_ok),
        .fault    (fault),
        .retry_cnt(retry_cnt),
        .loss_cnt (loss_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: phases with absolute deadlines (edge numbers) instead of a running timer.
    localparam int M_RST = 0, M_WAIT = 1, M_CHK = 2, M_RUN = 3, M_FAULT = 4;
    int     m_mode    = M_RST;
    longint m_edge    = 0;
    longint m_due     = P_RST;
    int     m_retries = 0;
    int     m_losses  = 0;
    bit     m_d1      = 1'b0;
    bit     m_d2      = 1'b0;

    task automatic model_edge(input bit r, input bit l);
        bit ls;
        ls = m_d2;
        m_edge++;
        if (r) begin
            m_mode = M_RST; m_due = m_edge + P_RST;
            m_retries = 0; m_losses = 0; m_d1 = 1'b0; m_d2 = 1'b0;
        end else begin
            case (m_mode)
                M_RST: if (m_edge == m_due) begin m_mode = M_WAIT; m_due = m_edge + P_WAIT; end
                M_WAIT: begin
                    if (ls) begin
                        m_mode = M_CHK; m_due = m_edge + P_STAB;
                    end else if (m_edge == m_due) begin
                        m_retries++;
                        if (m_retries == P_MAXR) m_mode = M_FAULT;
                        else begin m_mode = M_RST; m_due = m_edge + P_RST; end
                    end
                end
                M_CHK: begin
                    if (!ls) begin
                        m_mode = M_WAIT; m_due = m_edge + P_WAIT;
                    end else if (m_edge == m_due) begin
                        m_mode = M_RUN; m_retries = 0;
                    end
                end
                M_RUN: if (!ls) begin
                    m_losses = (m_losses < 255) ? m_losses + 1 : 255;
                    m_mode = M_RST; m_due = m_edge + P_RST;
                end
                default: ;
            endcase
            m_d2 = m_d1;
            m_d1 = l;
        end
    endtask

    function automatic logic [13:0] model_out();
        return {m_mode == M_RST, m_mode != M_RUN, m_mode == M_RUN, m_mode == M_FAULT,
                2'(m_retries), 8'(m_losses)};
    endfunction

    function automatic logic [13:0] outs();
        return {pll_reset, sys_rst, locked_ok, fault, retry_cnt, loss_cnt};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, advance model at the edge, compare 1 ns later.
    task automatic step(input bit r, input bit l);
        rst      = r;
        pll_lock = l;
        @(posedge clk);
        model_edge(r, l);
        #1;
        check($sformatf("model@%0d", m_edge), 32'(outs()), 32'(model_out()));
    endtask

    function automatic bit sel(input int s);
        case (s)
            SIG_PR:  return pll_reset;
            SIG_SR:  return sys_rst;
            default: return fault;
        endcase
    endfunction

    // Step until the chosen output reaches 'want' or 'limit' steps pass; n = steps taken.
    task automatic run_until(input int s, input bit want, input bit l, input int limit, output int n);
        n = 0;
        do begin
            step(1'b0, l);
            n++;
        end while (sel(s) != want && n < limit);
    endtask

    typedef struct {
        bit          r;
        bit          l;
        int          n;
        logic [13:0] exp;
    } vec_t;

    function automatic vec_t mk(input bit r, input bit l, input int n, input bit pr, input bit sr,
                                input bit ok, input bit fl, input int rc, input int lc);
        vec_t v;
        v.r = r; v.l = l; v.n = n;
        v.exp = {pr, sr, ok, fl, 2'(rc), 8'(lc)};
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int bad;
        int lv;
        int left;

        rst = 1'b1;
        pll_lock = 1'b0;

        //                 rst  lock  n   prst srst ok  flt rc lc
        // nominal lock
        tbl.push_back(mk(1'b1, 1'b0, 3,  1'b1, 1'b1, 1'b0, 1'b0, 0, 0));
        tbl.push_back(mk(1'b0, 1'b0, 3,  1'b1, 1'b1, 1'b0, 1'b0, 0, 0));
        tbl.push_back(mk(1'b0, 1'b0, 6,  1'b0, 1'b1, 1'b0, 1'b0, 0, 0));
        tbl.push_back(mk(1'b0, 1'b1, 10, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0));
        tbl.push_back(mk(1'b0, 1'b1, 1,  1'b0, 1'b0, 1'b1, 1'b0, 0, 0));
        tbl.push_back(mk(1'b0, 1'b1, 5,  1'b0, 1'b0, 1'b1, 1'b0, 0, 0));
        // loss in RUN: visible on the third low sample, then a 4-cycle pulse
        tbl.push_back(mk(1'b0, 1'b0, 2,  1'b0, 1'b0, 1'b1, 1'b0, 0, 0));
        tbl.push_back(mk(1'b0, 1'b0, 4,  1'b1, 1'b1, 1'b0, 1'b0, 0, 1));
        tbl.push_back(mk(1'b0, 1'b0, 1,  1'b0, 1'b1, 1'b0, 1'b0, 0, 1));
        // glitch 5 cycles into the stable check, then a fresh 8-cycle qualification
        tbl.push_back(mk(1'b0, 1'b1, 8,  1'b0, 1'b1, 1'b0, 1'b0, 0, 1));
        tbl.push_back(mk(1'b0, 1'b0, 2,  1'b0, 1'b1, 1'b0, 1'b0, 0, 1));
        tbl.push_back(mk(1'b0, 1'b1, 10, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1));
        tbl.push_back(mk(1'b0, 1'b1, 1,  1'b0, 1'b0, 1'b1, 1'b0, 0, 1));
        // second loss, then rst in the middle of the stable check
        tbl.push_back(mk(1'b0, 1'b0, 2,  1'b0, 1'b0, 1'b1, 1'b0, 0, 1));
        tbl.push_back(mk(1'b0, 1'b0, 4,  1'b1, 1'b1, 1'b0, 1'b0, 0, 2));
        tbl.push_back(mk(1'b0, 1'b0, 1,  1'b0, 1'b1, 1'b0, 1'b0, 0, 2));
        tbl.push_back(mk(1'b0, 1'b1, 5,  1'b0, 1'b1, 1'b0, 1'b0, 0, 2));
        tbl.push_back(mk(1'b1, 1'b1, 1,  1'b1, 1'b1, 1'b0, 1'b0, 0, 0));
        tbl.push_back(mk(1'b0, 1'b1, 3,  1'b1, 1'b1, 1'b0, 1'b0, 0, 0));
        // lock already high when WAIT_LOCK is entered
        tbl.push_back(mk(1'b0, 1'b1, 1,  1'b0, 1'b1, 1'b0, 1'b0, 0, 0));
        tbl.push_back(mk(1'b0, 1'b1, 8,  1'b0, 1'b1, 1'b0, 1'b0, 0, 0));
        tbl.push_back(mk(1'b0, 1'b1, 1,  1'b0, 1'b0, 1'b1, 1'b0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            for (int c = 0; c < tbl[i].n; c++) begin
                step(tbl[i].r, tbl[i].l);
                check($sformatf("vec%0d.%0d", i, c), 32'(outs()), 32'(tbl[i].exp));
            end
        end

        // Retry then success
        repeat (3) step(1'b1, 1'b0);
        run_until(SIG_PR, 1'b0, 1'b0, 50, n);
        check("retry_pulse1_len", n, P_RST);
        run_until(SIG_PR, 1'b1, 1'b0, 50, n);
        check("retry_wait_timeout", n, P_WAIT);
        check("retry_cnt_after_timeout", 32'(retry_cnt), 1);
        run_until(SIG_PR, 1'b0, 1'b0, 50, n);
        check("retry_pulse2_len", n, P_RST);
        run_until(SIG_SR, 1'b0, 1'b1, 60, n);
        check("retry_release_latency", n, 2 + 1 + P_STAB);
        check("retry_cnt_cleared", 32'(retry_cnt), 0);
        check("retry_locked_ok", 32'(locked_ok), 1);

        // Fault: two failed attempts, then terminal until rst
        repeat (3) step(1'b1, 1'b0);
        run_until(SIG_FLT, 1'b1, 1'b0, 200, n);
        check("fault_entry_time", n, 2 * (P_RST + P_WAIT));
        check("fault_retry_cnt", 32'(retry_cnt), P_MAXR);
        check("fault_pll_reset", 32'(pll_reset), 0);
        check("fault_sys_rst", 32'(sys_rst), 1);
        check("fault_locked_ok", 32'(locked_ok), 0);
        bad = 0;
        repeat (100) begin
            step(1'b0, 1'($urandom % 2));
            if ({pll_reset, sys_rst, locked_ok, fault, retry_cnt} !== 6'b0101_10) bad++;
        end
        check("fault_hold_100", bad, 0);
        step(1'b1, 1'b0);
        check("fault_rst_clears", 32'(outs()), 32'(14'b1100_00_00000000));

        // Loss counter saturation over 256 losses
        repeat (2) step(1'b1, 1'b1);
        for (int i = 0; i < 256; i++) begin
            run_until(SIG_SR, 1'b0, 1'b1, 60, n);
            check($sformatf("loss%0d_relock", i), 32'(n < 60), 1);
            run_until(SIG_SR, 1'b1, 1'b0, 10, n);
            check($sformatf("loss%0d_latency", i), n, 3);
            if (i == 0) check("loss_first_count", 32'(loss_cnt), 1);
        end
        check("loss_saturated", 32'(loss_cnt), 255);

        // Randomized runs of lock/no-lock with occasional rst, checked against the model
        repeat (2) step(1'b1, 1'b0);
        lv = 0;
        left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (left == 0) begin
                lv = 1 - lv;
                if ($urandom % 4 == 0) left = $urandom_range(1, 3);
                else if ($urandom % 3 == 0) left = $urandom_range(4, 70);
                else left = $urandom_range(4, 30);
            end
            left--;
            step(($urandom % 400) == 0, 1'(lv));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
